// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage for a multi-cycle core. A two-state FSM alternates
//   between FETCH (request the word at PC from instruction memory) and DECODE
//   (hold the word in IR for the decoder until downstream releases it). On
//   release, the next PC is selected from the redirect inputs and the FSM
//   returns to FETCH.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   imem_req/addr       instruction-memory read request and word address
//   imem_rdata/ready    returned instruction and its valid strobe
//   stall               hold the current instruction in DECODE
//   branch, branch_taken, jump, jump_reg, exce_ret, sys
//                       decoded control for the held instruction
//   reg_rs, epc         jr target and eret return address
//   instr, op, funct, mf
//                       held instruction and its decoder fields
//   valid               IR holds an instruction to decode
//   pc_out, pc_plus4    address of IR and its link value
//   epc_we, epc_wdata   exception-PC write to CP0 on syscall
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        exce_ret,
  input  logic        sys,
  input  logic [31:0] reg_rs,
  input  logic [31:0] epc,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  mf,
  output logic        valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        epc_we,
  output logic [31:0] epc_wdata
);

  typedef enum logic {
    FETCH  = 1'b0,
    DECODE = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        load_ir;
  logic        load_pc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc_raw;
  logic [31:0] next_pc;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load_ir    = 1'b0;
    load_pc    = 1'b0;
    imem_req   = 1'b0;
    epc_we     = 1'b0;
    unique case (state)
      FETCH: begin
        // The request is suppressed while reset is held, so a ready strobe
        // arriving during reset has nothing to answer.
        imem_req = ~rst;
        if (imem_ready && !rst) begin
          load_ir    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // Redirect inputs only matter on the release edge; while stalled
        // they are not looked at.
        if (!stall) begin
          load_pc    = 1'b1;
          epc_we     = sys;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-PC selection (highest priority first)
  // ---------------------------------------------------------------------------
  always_comb begin
    branch_target = pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00};
    jump_target   = {pc_plus4[31:28], ir[25:0], 2'b00};
    if (sys) begin
      next_pc_raw = EXC_VECTOR;
    end else if (exce_ret) begin
      next_pc_raw = epc;
    end else if (jump_reg) begin
      next_pc_raw = reg_rs;
    end else if (jump) begin
      next_pc_raw = jump_target;
    end else if (branch && branch_taken) begin
      next_pc_raw = branch_target;
    end else begin
      next_pc_raw = pc_plus4;
    end
    // Fetches are word-aligned; unaligned jr/eret targets are truncated.
    next_pc = {next_pc_raw[31:2], 2'b00};
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: PC, IR and the address of IR
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      ir    <= '0;
      ir_pc <= RESET_PC;
    end else begin
      if (load_ir) begin
        ir    <= imem_rdata;
        ir_pc <= pc;
      end
      if (load_pc) begin
        pc <= next_pc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_addr = pc;
  assign instr     = ir;
  assign op        = ir[31:26];
  assign mf        = ir[25:21];
  assign funct     = ir[5:0];
  assign valid     = (state == DECODE);
  assign pc_out    = ir_pc;
  assign pc_plus4  = ir_pc + 32'd4;
  // Only driven alongside the write strobe, so CP0 sees zero otherwise.
  assign epc_wdata = epc_we ? pc_plus4 : 32'h0000_0000;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning first fetch address after reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, meaning target address for syscall.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port imem_ready  input  1  imem_rdata is valid this cycle.
REQ-009 SHALL have port stall  input  1  downstream hold; current instruction is not retired.
REQ-010 SHALL have ports branch, branch_taken, jump, jump_reg, exce_ret, sys  input  1 each  decoded control for the held instruction and the datapath compare result.
REQ-011 SHALL have port reg_rs  input  32  jr target register value.
REQ-012 SHALL have port epc  input  32  eret return address.
REQ-013 SHALL have port instr  output  32  held instruction register (IR).
REQ-014 SHALL have ports op  output  6  (IR[31:26]), funct  output  6  (IR[5:0]), mf  output  5  (IR[25:21]), the decoder inputs.
REQ-015 SHALL have port valid  output  1  IR holds an instruction to decode.
REQ-016 SHALL have ports pc_out  output  32  (address of IR) and pc_plus4  output  32  (pc_out+4, jal link value).
REQ-017 SHALL have ports epc_we  output  1  and epc_wdata  output  32  exception-PC write to CP0.

Function
REQ-018 SHALL implement a two-state FSM, FETCH and DECODE.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the PC register.
REQ-020 In FETCH, on an edge with imem_ready=1, IR<=imem_rdata, pc_out<=PC, valid<=1, state<=DECODE; imem_ready in the same cycle req rises is accepted (minimum fetch latency 1 cycle).
REQ-021 imem_ready while imem_req=0 SHALL be ignored.
REQ-022 In DECODE, imem_req SHALL be 0 and valid SHALL be 1.
REQ-023 In DECODE with stall=1, IR, pc_out, PC and state SHALL hold; redirect inputs are not sampled.
REQ-024 In DECODE with stall=0, on the edge PC<=next-PC, valid<=0, state<=FETCH.
REQ-025 Next-PC priority, highest first: sys -> EXC_VECTOR; exce_ret -> epc; jump_reg -> reg_rs; jump -> {pc_plus4[31:28], IR[25:0], 2'b00}; branch&branch_taken -> pc_plus4 + (signext(IR[15:0])<<2); else pc_plus4.
REQ-026 Simultaneous redirects SHALL resolve strictly by REQ-025 priority; no delay slot.
REQ-027 Next-PC bits [1:0] SHALL be forced to 2'b00 (misaligned jr/eret targets truncate).
REQ-028 All PC arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000; branch offsets wrap likewise).
REQ-029 epc_we SHALL pulse high for exactly the one cycle in DECODE with stall=0 and sys=1, with epc_wdata = pc_plus4; otherwise epc_we=0.
REQ-030 stall SHALL have no effect in FETCH; an in-flight fetch completes.

Reset
REQ-031 While rst=1: PC=RESET_PC, state=FETCH, imem_req=0, valid=0, instr=0, pc_out=RESET_PC, epc_we=0, epc_wdata=0.
REQ-032 Reset asserted mid-fetch or mid-stall SHALL abort immediately; an imem_ready coinciding with rst SHALL be discarded.
REQ-033 First cycle after rst falls: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-034 Reset release, imem_ready=1 next cycle, rdata=32'h2008_0005 -> valid=1, op=6'b001000, pc_out=32'h0000_3000; after stall=0, imem_addr=32'h0000_3004.
REQ-035 beq at 32'h0000_3010, IR[15:0]=16'hFFFE, branch=1, branch_taken=1 -> next imem_addr=32'h0000_300C; branch_taken=0 -> 32'h0000_3014.
REQ-036 stall=1 for 5 cycles in DECODE with jump=1 -> IR/pc_out stable, imem_req=0 throughout; on release imem_addr=jump target.
REQ-037 sys=1, exce_ret=1, jump_reg=1 together at pc_out=32'h0000_3020 -> imem_addr=EXC_VECTOR, one-cycle epc_we with epc_wdata=32'h0000_3024; later exce_ret alone, epc=32'h0000_3026 -> imem_addr=32'h0000_3024.
REQ-038 PC=32'hFFFF_FFFC, no redirect -> next imem_addr=32'h0000_0000; rst pulse with imem_ready high mid-fetch -> valid stays 0, refetch at RESET_PC.
